hoeraa_core: RTL and testbench

HOERAA_CORE -- requirements
Module: hoeraa

---
 rtl/hoeraa_core_if.sv | 22 ++
 rtl/hoeraa_core.sv | 64 ++++++
 tb/tb_hoeraa_core.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hoeraa_core_if.sv
// Operand/result bus of the hoeraa approximate adder: one valid-qualified
// operand pair in, one valid-qualified sum/carry out, no backpressure.
interface hoeraa_core_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic         out_valid;
    logic [N-1:0] S;
    logic         Co;

    modport master (
        output in_valid, X, Y,
        input  out_valid, S, Co
    );

    modport slave (
        input  in_valid, X, Y,
        output out_valid, S, Co
    );
endinterface

// File: rtl/hoeraa_core.sv
// HOERAA approximate adder: exact upper (N-K) bits, heuristic low K bits,
// result registered one cycle after an accepted operand pair.
module hoeraa_core #(
    parameter int N = 16,
    parameter int K = 8
) (
    input logic          clk,
    input logic          rst_n,
    hoeraa_core_if.slave bus
);

    // Low K bits: the top bit ORs the operand MSBs with the predicted carry,
    // the rest saturate to ones unless a carry out of bit K-2 is predicted.
    function automatic logic [K-1:0] approx_low(input logic x_top, input logic y_top,
                                                input logic sel);
        approx_low = {x_top | y_top | sel, {(K-1){~sel}}};
    endfunction

    function automatic logic [N-K:0] exact_high(input logic [N-K-1:0] a,
                                                input logic [N-K-1:0] b,
                                                input logic           cin);
        exact_high = {1'b0, a} + {1'b0, b} + {{(N-K){1'b0}}, cin};
    endfunction

    logic         c_k;
    logic         sel;
    logic [N-K:0] hi_sum_p0;
    logic [K-1:0] lo_sum_p0;
    logic         unused_low_bits;

    logic [N-1:0] s_p1;
    logic         co_p1;
    logic         vld_p1;

    always_comb begin
        c_k       = bus.X[K-1] & bus.Y[K-1];
        sel       = bus.X[K-2] & bus.Y[K-2];
        hi_sum_p0 = exact_high(bus.X[N-1:K], bus.Y[N-1:K], c_k);
        lo_sum_p0 = approx_low(bus.X[K-1], bus.Y[K-1], sel);
    end

    // Bits below K-2 never influence the result.
    assign unused_low_bits = ^{bus.X, bus.Y};

    // ---- stage p0 -> p1 : register result, hold it while idle ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            s_p1   <= '0;
            co_p1  <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                s_p1  <= {hi_sum_p0[N-K-1:0], lo_sum_p0};
                co_p1 <= hi_sum_p0[N-K];
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.S         = s_p1;
    assign bus.Co        = co_p1;

endmodule

// File: tb/tb_hoeraa_core.sv
// Scoreboard bench for hoeraa_core (N=16, K=8) driven by hand-computed vectors.
module tb_hoeraa_core;

    localparam int N = 16;
    localparam int K = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    typedef struct packed {
        logic [N-1:0] s;
        logic         co;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] hold_s;
    logic         hold_co;

    hoeraa_core_if #(.N(N)) bus ();

    hoeraa_core #(.N(N), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare presented results against the queue, check hold when idle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", {16'h0, bus.out_valid}, 17'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_S", {1'b0, bus.S}, {1'b0, e.s});
                    check("result_Co", {16'h0, bus.Co}, {16'h0, e.co});
                    hold_s  = e.s;
                    hold_co = e.co;
                end
            end else begin
                check("hold_S", {1'b0, bus.S}, {1'b0, hold_s});
                check("hold_Co", {16'h0, bus.Co}, {16'h0, hold_co});
                check("idle_out_valid", {16'h0, bus.out_valid}, 17'h0);
            end
        end
    end

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] s, input logic co);
        @(posedge clk);
        #1;
        bus.X        = x;
        bus.Y        = y;
        bus.in_valid = 1'b1;
        exp_q.push_back('{s: s, co: co});
    endtask

    task automatic idle(input logic [N-1:0] x, input logic [N-1:0] y);
        @(posedge clk);
        #1;
        bus.X        = x;
        bus.Y        = y;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        hold_s       = '0;
        hold_co      = 1'b0;
        bus.in_valid = 1'b0;
        bus.X        = '0;
        bus.Y        = '0;
        rst_n        = 1'b0;
        #1;
        check("reset_S", {1'b0, bus.S}, 17'h0);
        check("reset_Co", {16'h0, bus.Co}, 17'h0);
        check("reset_out_valid", {16'h0, bus.out_valid}, 17'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        send(16'h0001, 16'h0001, 16'h007F, 1'b0);
        send(16'h00FF, 16'h00FF, 16'h0180, 1'b0);
        send(16'hFFFF, 16'hFFFF, 16'hFF80, 1'b1);
        send(16'h5555, 16'hAAAA, 16'hFFFF, 1'b0);
        send(16'h8001, 16'h0101, 16'h817F, 1'b0);
        send(16'h0101, 16'h8001, 16'h817F, 1'b0);
        idle(16'hFFFF, 16'hFFFF);
        idle(16'h1234, 16'h4321);
        send(16'h0040, 16'h0040, 16'h0080, 1'b0);
        send(16'h8000, 16'h8000, 16'h007F, 1'b1);
        idle(16'h00FF, 16'h00FF);
        send(16'h003F, 16'h00C0, 16'h00FF, 1'b0);
        send(16'h1234, 16'h0000, 16'h127F, 1'b0);
        send(16'hFF80, 16'h0080, 16'h00FF, 1'b1);
        send(16'hAAAA, 16'h5555, 16'hFFFF, 1'b0);

        // Mid-stream asynchronous reset while a result is being presented.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_S", {1'b0, bus.S}, 17'h0);
        check("async_reset_Co", {16'h0, bus.Co}, 17'h0);
        check("async_reset_out_valid", {16'h0, bus.out_valid}, 17'h0);
        exp_q.delete();
        hold_s  = '0;
        hold_co = 1'b0;

        // Operands offered during reset must be discarded.
        bus.X        = 16'hFFFF;
        bus.Y        = 16'hFFFF;
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("in_reset_out_valid", {16'h0, bus.out_valid}, 17'h0);
        check("in_reset_S", {1'b0, bus.S}, 17'h0);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('{s: 16'hFF80, co: 1'b1});
        idle(16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000);

        begin
            int budget;
            budget = 0;
            while (exp_q.size() != 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            repeat (2) @(posedge clk);
            check("queue_drained", {1'b0, 16'(exp_q.size())}, 17'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
